// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the core and
// the accelerator: FSM state encoding, read-owner encoding and the default
// starvation limit.
package dmem_arb_pkg;

  // The state records who owned the grant in the previous cycle.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CORE_OWN = 2'd1,
    ACC_OWN  = 2'd2
  } state_e;

  // Owner of an outstanding read, used to steer the response.
  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_ACC  = 1'b1
  } owner_e;

  // Number of consecutive losing accelerator cycles before it is forced in.
  localparam int STARVE_LIMIT_DEF = 4;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arb_if.sv
// Bundle of the core, accelerator and memory-side signals of the data-memory
// arbiter. The slave modport is the arbiter's view; the master modport is the
// view of the requesters together with the memory.
interface dmem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  // Core port
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [MASK_W-1:0] core_mask;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  // Accelerator port
  logic              acc_req;
  logic              acc_lock;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [MASK_W-1:0] acc_mask;
  logic              acc_gnt;
  logic              acc_rvalid;
  logic [DATA_W-1:0] acc_rdata;

  // Memory port
  logic              mem_cs;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_mask;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_mask,
    output core_gnt, core_rvalid, core_rdata,
    input  acc_req, acc_lock, acc_we, acc_addr, acc_wdata, acc_mask,
    output acc_gnt, acc_rvalid, acc_rdata,
    output mem_cs, mem_read, mem_addr, mem_wdata, mem_mask,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_mask,
    input  core_gnt, core_rvalid, core_rdata,
    output acc_req, acc_lock, acc_we, acc_addr, acc_wdata, acc_mask,
    input  acc_gnt, acc_rvalid, acc_rdata,
    input  mem_cs, mem_read, mem_addr, mem_wdata, mem_mask,
    output mem_rdata
  );

endinterface : dmem_arb_if

// File: rtl/dmem_resp_router.sv
// Read-response router: remembers which requester issued the read granted in
// the previous cycle and steers the memory's one-cycle-late data back to it.
module dmem_resp_router
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_rd,
  input  logic              acc_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              core_rvalid,
  output logic              core_rdata_unused_n,
  output logic              acc_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic [DATA_W-1:0] acc_rdata
);

  logic   vld_p1;
  owner_e owner_p1;

  // Capture read issue and its owner; reset drops any response in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      owner_p1 <= OWN_CORE;
    end else begin
      vld_p1 <= core_rd | acc_rd;
      if (core_rd | acc_rd) begin
        owner_p1 <= acc_rd ? OWN_ACC : OWN_CORE;
      end
    end
  end

  // ---- stage p1: memory data arrives, routed by the registered owner ----
  assign core_rvalid = vld_p1 && (owner_p1 == OWN_CORE);
  assign acc_rvalid  = vld_p1 && (owner_p1 == OWN_ACC);
  assign core_rdata  = mem_rdata;
  assign acc_rdata   = mem_rdata;

  // Constant-high marker; keeps the port list stable for integrators.
  assign core_rdata_unused_n = 1'b1;

endmodule : dmem_resp_router

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (core vs. accelerator).
// Default build: core has priority, an accelerator locked burst is never
// interrupted, and a starvation counter forces the accelerator in after
// STARVE_LIMIT consecutive losing cycles.
// Build option: define DMEM_ARB_ROUND_ROBIN_EN to replace fixed priority and
// starvation counting by round-robin on contended cycles (acc_lock still wins).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_arb_if.slave  bus
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_e            state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              lock_hold;
  logic              acc_pri;
  logic              core_gnt;
  logic              acc_gnt;

  logic              mem_cs_c;
  logic              mem_read_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [MASK_W-1:0] mem_mask_c;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;
  logic              router_tie;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic rr_acc_pri;
  logic contended;

  assign contended  = bus.core_req && bus.acc_req;
  assign starve_cnt = '0;
`else
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction
`endif

  // Grant decision: lock hold first, then the contention tie-break.
  always_comb begin
    lock_hold = (state == ACC_OWN) && bus.acc_req && bus.acc_lock;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    acc_pri   = rr_acc_pri;
`else
    acc_pri   = (starve_cnt == CNT_MAX);
`endif
    acc_gnt   = rst_n && bus.acc_req && (lock_hold || !bus.core_req || acc_pri);
    core_gnt  = rst_n && bus.core_req && !acc_gnt;
  end

  // Ownership FSM plus tie-break bookkeeping for the next contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      rr_acc_pri <= 1'b0;
`else
      starve_cnt <= '0;
`endif
    end else begin
      if (core_gnt)     state <= CORE_OWN;
      else if (acc_gnt) state <= ACC_OWN;
      else              state <= IDLE;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      // The loser of a contended cycle gets priority next time.
      if (contended) rr_acc_pri <= core_gnt;
`else
      if (!bus.acc_req || acc_gnt) starve_cnt <= '0;
      else                         starve_cnt <= sat_inc(starve_cnt);
`endif
    end
  end

  // Memory request mux: the granted requester drives the memory this cycle.
  always_comb begin
    mem_cs_c    = core_gnt | acc_gnt;
    mem_read_c  = 1'b0;
    mem_mask_c  = '0;
    mem_addr_c  = addr_hold;
    mem_wdata_c = wdata_hold;
    if (core_gnt) begin
      mem_read_c  = !bus.core_we;
      mem_addr_c  = bus.core_addr;
      mem_wdata_c = bus.core_wdata;
      mem_mask_c  = bus.core_we ? bus.core_mask : '1;
    end else if (acc_gnt) begin
      mem_read_c  = !bus.acc_we;
      mem_addr_c  = bus.acc_addr;
      mem_wdata_c = bus.acc_wdata;
      mem_mask_c  = bus.acc_we ? bus.acc_mask : '1;
    end
  end

  // Keep the last issued address/data so idle cycles do not toggle the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else if (mem_cs_c) begin
      addr_hold  <= mem_addr_c;
      wdata_hold <= mem_wdata_c;
    end
  end

  assign bus.core_gnt  = core_gnt;
  assign bus.acc_gnt   = acc_gnt;
  assign bus.mem_cs    = mem_cs_c;
  assign bus.mem_read  = mem_read_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_mask  = mem_mask_c;

  dmem_resp_router #(
    .DATA_W (DATA_W)
  ) u_resp_router (
    .clk                 (clk),
    .rst_n               (rst_n),
    .core_rd             (core_gnt && !bus.core_we),
    .acc_rd              (acc_gnt && !bus.acc_we),
    .mem_rdata           (bus.mem_rdata),
    .core_rvalid         (bus.core_rvalid),
    .core_rdata_unused_n (router_tie),
    .acc_rvalid          (bus.acc_rvalid),
    .core_rdata          (bus.core_rdata),
    .acc_rdata           (bus.acc_rdata)
  );

  // The router's tie-high marker carries no information here.
  logic unused_ok;
  assign unused_ok = router_tie;

endmodule : dmem_arbiter
